// File: rtl/alu_defs.sv
// ============================================================================
// Module : alu_defs
// Shared opcode, FSM state and opcode-legality definitions for alu_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_defs;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // 3'b100 and 3'b101 are the only unused encodings.
    function automatic logic is_legal_op(input logic [2:0] op);
        return !((op == 3'b100) || (op == 3'b101));
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
// ============================================================================
// Module : ALU
// Combinational ALU: AND, OR, ADD, SUB, LUI and unsigned SLT.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ALU
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_LUI: o_result = i_b << 16;
            ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module : alu_arbiter
// Round-robin two-requester front end and IDLE/EXEC/RESP sequencer for the ALU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t             r_state;
    logic               r_last_grant;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_id;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_err;
    logic [CNT_W-1:0]   r_ops_done;

    logic               w_grant;
    logic               w_grant_id;
    logic [2:0]         w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_zero;

    // With both valid, the requester not granted last wins; otherwise the lone one.
    assign w_grant    = (r_state == S_IDLE) && (req0_valid || req1_valid);
    assign w_grant_id = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    assign req0_ready = w_grant && !w_grant_id;
    assign req1_ready = w_grant &&  w_grant_id;

    assign w_sel_op = w_grant_id ? req1_op : req0_op;
    assign w_sel_a  = w_grant_id ? req1_a  : req0_a;
    assign w_sel_b  = w_grant_id ? req1_b  : req0_b;

    ALU #(
        .WIDTH    (WIDTH)
    ) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_alu_result),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= 3'b000;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_op         <= w_sel_op;
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_legal_op(r_op)) begin
                        r_rsp_result <= w_alu_result;
                        r_rsp_zero   <= w_alu_zero;
                        r_rsp_err    <= 1'b0;
                    end else begin
                        r_rsp_result <= '0;
                        r_rsp_zero   <= 1'b1;
                        r_rsp_err    <= 1'b1;
                    end
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != S_IDLE);
    assign ops_done   = r_ops_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module : tb_alu_arbiter
// Self-checking bench for alu_arbiter: vector table, scoreboard, corner cases.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int TB_CNT_W = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [31:0] rsp_result;
    logic [TB_CNT_W-1:0] ops_done;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy), .ops_done(ops_done)
    );

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    int tests = 0;
    int fails = 0;
    rsp_t sb[$];
    int   grants[$];
    int   exp_ops = 0;
    int   rsp_count = 0;
    rsp_t last;
    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rsp_t model(input logic id, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        r.id  = id;
        r.err = 1'b0;
        case (op)
            3'b000: r.result = a & b;
            3'b001: r.result = a | b;
            3'b010: r.result = a + b;
            3'b110: r.result = a - b;
            3'b011: r.result = {b[15:0], 16'h0000};
            3'b111: r.result = (a < b) ? 32'd1 : 32'd0;
            default: begin r.result = 32'd0; r.err = 1'b1; end
        endcase
        r.zero = (r.result == 32'd0);
        return r;
    endfunction

    // Scoreboard: push on grant, pop on response handshake.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            exp_ops = 0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("single_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                check("ready_not_busy", {31'd0, busy}, 32'd0);
            end
            if (req0_valid && req0_ready) begin
                sb.push_back(model(1'b0, req0_op, req0_a, req0_b));
                grants.push_back(0);
            end
            if (req1_valid && req1_ready) begin
                sb.push_back(model(1'b1, req1_op, req1_a, req1_b));
                grants.push_back(1);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    rsp_t e;
                    e = sb.pop_front();
                    check("sb_id",     {31'd0, rsp_id},   {31'd0, e.id});
                    check("sb_result", rsp_result,        e.result);
                    check("sb_zero",   {31'd0, rsp_zero}, {31'd0, e.zero});
                    check("sb_err",    {31'd0, rsp_err},  {31'd0, e.err});
                end
                check("ops_done", {28'd0, ops_done}, exp_ops % (1 << TB_CNT_W));
                exp_ops++;
                last.id = rsp_id; last.result = rsp_result;
                last.zero = rsp_zero; last.err = rsp_err;
                rsp_count++;
            end
        end
    end

    task automatic issue(input int r, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        bit ok = 1'b0;
        @(posedge clk); #1;
        if (r == 0) begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        else        begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) begin ok = 1'b1; break; end
        end
        check("grant_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        if (r == 0) req0_valid = 0; else req1_valid = 0;
    endtask

    task automatic wait_resp(input int target);
        int k = 0;
        while (rsp_count < target && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rsp_timeout", {31'd0, rsp_count >= target}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1;
        @(negedge clk);
        @(posedge clk); #1 reset = 0;
    endtask

    initial begin
        int n;
        tbl[0]  = '{3'b010, 32'd7,         32'd5,         32'd12,         1'b0, 1'b0};
        tbl[1]  = '{3'b000, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF,  1'b0, 1'b0};
        tbl[2]  = '{3'b001, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF,  1'b0, 1'b0};
        tbl[3]  = '{3'b110, 32'd5,         32'd5,         32'd0,          1'b1, 1'b0};
        tbl[4]  = '{3'b110, 32'd0,         32'd1,         32'hFFFF_FFFF,  1'b0, 1'b0};
        tbl[5]  = '{3'b010, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1, 1'b0};
        tbl[6]  = '{3'b011, 32'd0,         32'h0000_1234, 32'h1234_0000,  1'b0, 1'b0};
        tbl[7]  = '{3'b011, 32'hDEAD_BEEF, 32'hABCD_1234, 32'h1234_0000,  1'b0, 1'b0};
        tbl[8]  = '{3'b111, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1, 1'b0};
        tbl[9]  = '{3'b111, 32'd1,         32'hFFFF_FFFF, 32'd1,          1'b0, 1'b0};
        tbl[10] = '{3'b111, 32'd5,         32'd5,         32'd0,          1'b1, 1'b0};
        tbl[11] = '{3'b101, 32'd3,         32'd4,         32'd0,          1'b1, 1'b1};
        tbl[12] = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b1, 1'b1};

        reset = 1; rsp_ready = 1;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_id",    {31'd0, rsp_id},    32'd0);
        check("rst_result",    rsp_result,         32'd0);
        check("rst_zero",      {31'd0, rsp_zero},  32'd0);
        check("rst_err",       {31'd0, rsp_err},   32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_ops",       {28'd0, ops_done},  32'd0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        check("idle_no_ready", {30'd0, req1_ready, req0_ready}, 32'd0);

        // Single request with exact latency.
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'b010; req0_a = 32'd7; req0_b = 32'd5;
        @(negedge clk);
        check("single_ready0", {31'd0, req0_ready}, 32'd1);
        check("single_ready1", {31'd0, req1_ready}, 32'd0);
        @(posedge clk); #1 req0_valid = 0;
        check("exec_busy",  {31'd0, busy},      32'd1);
        check("exec_noval", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        check("single_valid",  {31'd0, rsp_valid}, 32'd1);
        check("single_id",     {31'd0, rsp_id},    32'd0);
        check("single_result", rsp_result,         32'd12);
        check("single_zero",   {31'd0, rsp_zero},  32'd0);
        check("single_err",    {31'd0, rsp_err},   32'd0);
        @(posedge clk); #1;
        check("single_ops", {28'd0, ops_done}, 32'd1);
        check("single_idle", {31'd0, busy},    32'd0);

        for (int i = 0; i < 13; i++) begin
            n = rsp_count;
            issue(0, tbl[i].op, tbl[i].a, tbl[i].b);
            wait_resp(n + 1);
            check("tbl_id",     {31'd0, last.id},   32'd0);
            check("tbl_result", last.result,        tbl[i].res);
            check("tbl_zero",   {31'd0, last.zero}, {31'd0, tbl[i].zero});
            check("tbl_err",    {31'd0, last.err},  {31'd0, tbl[i].err});
        end

        // Back-pressure: response must hold and req0 must stall.
        rsp_ready = 0;
        n = rsp_count;
        grants.delete();
        issue(1, 3'b011, 32'd0, 32'h0000_1234);
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check("bp_valid", {31'd0, rsp_valid}, 32'd1);
        fork
            issue(0, 3'b000, 32'hFFFF_FFFF, 32'h5A5A_5A5A);
        join_none
        repeat (5) begin
            @(negedge clk);
            check("bp_result", rsp_result,          32'h1234_0000);
            check("bp_busy",   {31'd0, busy},       32'd1);
            check("bp_valid",  {31'd0, rsp_valid},  32'd1);
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
        end
        @(posedge clk); #1 rsp_ready = 1;
        wait_resp(n + 2);
        check("bp_ngrants", grants.size(), 32'd2);
        if (grants.size() == 2) begin
            check("bp_grant0", grants[0], 32'd1);
            check("bp_grant1", grants[1], 32'd0);
        end
        // 16 handshakes so far: the 4-bit counter has wrapped.
        @(posedge clk); #1;
        check("ops_wrap", {28'd0, ops_done}, 32'd0);
        n = rsp_count;
        issue(1, 3'b010, 32'd1, 32'd1);
        wait_resp(n + 1);
        @(posedge clk); #1;
        check("ops_after_wrap", {28'd0, ops_done}, 32'd1);

        // Contention from reset: requester 0 first, then strict alternation.
        pulse_reset();
        grants.delete();
        n = rsp_count;
        fork
            issue(0, 3'b110, 32'd5, 32'd5);
            issue(1, 3'b001, 32'h0000_00F0, 32'h0000_000F);
        join
        wait_resp(n + 2);
        check("cont_last_id",  {31'd0, last.id}, 32'd1);
        check("cont_last_res", last.result,      32'h0000_00FF);
        fork
            issue(0, 3'b010, 32'd10, 32'd20);
            issue(1, 3'b010, 32'd30, 32'd40);
        join
        wait_resp(n + 4);
        check("cont_ngrants", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            check("cont_g0", grants[0], 32'd0);
            check("cont_g1", grants[1], 32'd1);
            check("cont_g2", grants[2], 32'd0);
            check("cont_g3", grants[3], 32'd1);
        end

        // Reset while in EXEC drops the operation.
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 3'b010; req0_a = 32'd1; req0_b = 32'd2;
        @(negedge clk);
        check("mid_grant", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1 req0_valid = 0;
        check("mid_exec", {31'd0, busy}, 32'd1);
        #2 reset = 1;
        #1;
        check("mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_busy",      {31'd0, busy},      32'd0);
        check("mid_ops",       {28'd0, ops_done},  32'd0);
        @(negedge clk);
        @(posedge clk); #1 reset = 0;
        repeat (3) begin
            @(negedge clk);
            check("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        n = rsp_count;
        issue(1, 3'b010, 32'd100, 32'd23);
        wait_resp(n + 1);
        check("post_rst_id",  {31'd0, last.id}, 32'd1);
        check("post_rst_res", last.result,      32'd123);
        @(posedge clk); #1;
        check("post_rst_ops", {28'd0, ops_done}, 32'd1);
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
